// File: rtl/softmax_pkg.sv
// Shared state encoding and default widths for the softmax normalization stage.
package softmax_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned SUM_WIDTH  = 32;
    localparam int unsigned FRAC_BITS  = 15;
    localparam int unsigned ONE_Q      = 32'd1 << FRAC_BITS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        FETCH   = 3'd2,
        WAIT_RD = 3'd3,
        DIVIDE  = 3'd4,
        OUTPUT  = 3'd5,
        DONE    = 3'd6
    } norm_state_e;

endpackage

// File: rtl/softmax_normalizer_if.sv
// Sum input, exp-buffer read port, probability stream and status of the normalizer.
interface softmax_normalizer_if #(
    parameter int unsigned DATA_WIDTH = softmax_pkg::DATA_WIDTH,
    parameter int unsigned SUM_WIDTH  = softmax_pkg::SUM_WIDTH,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  sum_valid;
    logic [SUM_WIDTH-1:0]  sum_in;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  div_zero;

    modport master (
        input  sum_valid, sum_in, rd_data, out_ready,
        output rd_en, rd_addr, out_valid, out_data, out_last, busy, done, div_zero
    );

    modport slave (
        output sum_valid, sum_in, rd_data, out_ready,
        input  rd_en, rd_addr, out_valid, out_data, out_last, busy, done, div_zero
    );
endinterface

// File: rtl/softmax_normalizer_serial_divider.sv
// Restoring divider: the first quotient bit is produced on the start cycle, one more per cycle after.
module serial_divider #(
    parameter int unsigned DIVIDEND_WIDTH = 31,
    parameter int unsigned DIVISOR_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH:0]    remainder
);
    localparam int unsigned CNT_WIDTH = $clog2(DIVIDEND_WIDTH + 1);

    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [DIVISOR_WIDTH-1:0]  rem_src;
    logic [DIVISOR_WIDTH:0]    trial;
    logic [DIVISOR_WIDTH:0]    rem_nxt;
    logic [DIVIDEND_WIDTH-1:0] quo_src;
    logic [DIVIDEND_WIDTH-1:0] quo_nxt;
    logic                      fits;

    // One shift/compare/subtract step; the quotient register doubles as the dividend shifter.
    always_comb begin
        rem_src = start ? '0 : remainder[DIVISOR_WIDTH-1:0];
        quo_src = start ? dividend : quotient;
        trial   = {rem_src, quo_src[DIVIDEND_WIDTH-1]};
        fits    = (trial >= {1'b0, divisor});
        rem_nxt = fits ? (trial - {1'b0, divisor}) : trial;
        quo_nxt = {quo_src[DIVIDEND_WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                quotient  <= quo_nxt;
                remainder <= rem_nxt;
            end
            if (start) begin
                cnt_q <= CNT_WIDTH'(DIVIDEND_WIDTH - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/softmax_normalizer.sv
// Divides each buffered exponent by the captured sum and streams Q1.FRAC_BITS probabilities.
// Optional SOFTMAX_NORM_ROUND_EN: round-half-up quotient at the cost of one extra DIVIDE cycle.
module softmax_normalizer #(
    parameter int unsigned DATA_WIDTH = softmax_pkg::DATA_WIDTH,
    parameter int unsigned SUM_WIDTH  = softmax_pkg::SUM_WIDTH,
    parameter int unsigned IFM_SIZE   = 1000,
    parameter int unsigned FRAC_BITS  = softmax_pkg::FRAC_BITS,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    softmax_normalizer_if.master bus
);
    import softmax_pkg::*;

    localparam int unsigned QUO_WIDTH = DATA_WIDTH + FRAC_BITS;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IFM_SIZE - 1);

    norm_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d;
    logic                  div_zero_q, div_zero_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  div_start_c;
    logic                  div_busy;
    logic                  div_done;
    logic [QUO_WIDTH-1:0]  div_quo;
    logic [SUM_WIDTH:0]    div_rem;
    logic                  last_c;

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic [QUO_WIDTH:0] q);
        if (|q[QUO_WIDTH:DATA_WIDTH]) return '1;
        return q[DATA_WIDTH-1:0];
    endfunction

    assign last_c = (cnt_q == LAST_IDX);

    serial_divider #(
        .DIVIDEND_WIDTH (QUO_WIDTH),
        .DIVISOR_WIDTH  (SUM_WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_c),
        .dividend  ({bus.rd_data, {FRAC_BITS{1'b0}}}),
        .divisor   (sum_q),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

`ifdef SOFTMAX_NORM_ROUND_EN
    logic [QUO_WIDTH:0] rnd_q, rnd_d;
    logic               rnd_pend_q, rnd_pend_d;
    logic               unused_div;
    assign unused_div = &{1'b0, div_busy};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q      <= '0;
            rnd_pend_q <= 1'b0;
        end else begin
            rnd_q      <= rnd_d;
            rnd_pend_q <= rnd_pend_d;
        end
    end
`else
    logic unused_div;
    assign unused_div = &{1'b0, div_busy, div_rem};
`endif

    // Next-state and next-output decode; outputs are flopped so they track the state register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        div_zero_d  = div_zero_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_start_c = 1'b0;
`ifdef SOFTMAX_NORM_ROUND_EN
        rnd_d       = rnd_q;
        rnd_pend_d  = rnd_pend_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.sum_valid) begin
                    state_d    = LOAD;
                    sum_d      = bus.sum_in;
                    div_zero_d = (bus.sum_in == '0);
                    busy_d     = 1'b1;
                end
            end
            LOAD: begin
                cnt_d     = '0;
                rd_en_d   = 1'b1;
                rd_addr_d = '0;
                state_d   = FETCH;
            end
            FETCH: state_d = WAIT_RD;
            WAIT_RD: begin
                if (div_zero_q) begin
                    state_d     = OUTPUT;
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_last_d  = last_c;
                end else begin
                    div_start_c = 1'b1;
                    state_d     = DIVIDE;
                end
            end
            DIVIDE: begin
`ifdef SOFTMAX_NORM_ROUND_EN
                if (rnd_pend_q) begin
                    rnd_pend_d  = 1'b0;
                    state_d     = OUTPUT;
                    out_valid_d = 1'b1;
                    out_data_d  = saturate(rnd_q);
                    out_last_d  = last_c;
                end else if (div_done) begin
                    // Half rounds up: bump when 2*remainder >= divisor.
                    rnd_d      = {1'b0, div_quo} +
                                 (QUO_WIDTH + 1)'({div_rem, 1'b0} >= {2'b00, sum_q});
                    rnd_pend_d = 1'b1;
                end
`else
                if (div_done) begin
                    state_d     = OUTPUT;
                    out_valid_d = 1'b1;
                    out_data_d  = saturate({1'b0, div_quo});
                    out_last_d  = last_c;
                end
`endif
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (last_c) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + ADDR_WIDTH'(1);
                        rd_en_d   = 1'b1;
                        rd_addr_d = cnt_q + ADDR_WIDTH'(1);
                        state_d   = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sum_q       <= '0;
            div_zero_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            div_zero_q  <= div_zero_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = div_zero_q;
endmodule

// File: doc/softmax_normalizer.md
Name: softmax_normalizer

Overview:
- Downstream stage of the softmax controller.
- Consumes the exponent-sum partial sum, which the controller registers on `reg_write_psum`.
- Then reads back each per-element exponent value from the IFM/exp buffer and divides it by the sum.
- Emits normalized probabilities in unsigned Q1.FRAC_BITS format on a valid/ready stream, ending with `out_last` and a `done` pulse.

Parameters:
- DATA_WIDTH, 16: width of exponent values read from the buffer and of the output probability.
- SUM_WIDTH, 32: width of the accumulated exponent sum.
- IFM_SIZE, 1000: number of elements per softmax vector.
- FRAC_BITS, 15: fractional bits of the output. Output 1.0 = 2^FRAC_BITS.
- ADDR_WIDTH, 16: buffer read address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sum_valid  in  1  one-cycle pulse; `sum_in` is valid this cycle.
- sum_in  in  SUM_WIDTH  exponent sum for the vector.
- rd_en  out  1  buffer read request.
- rd_addr  out  ADDR_WIDTH  buffer read address.
- rd_data  in  DATA_WIDTH  buffer read data, valid exactly one cycle after `rd_en`.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  consumer accepts `out_data`.
- out_data  out  DATA_WIDTH  normalized probability.
- out_last  out  1  marks element IFM_SIZE-1.
- busy  out  1  high from sum capture until `done`.
- done  out  1  one-cycle pulse after the last handshake.
- div_zero  out  1  sticky: the captured sum was zero; cleared on the next accepted `sum_valid`.

Behaviour:

Reset:
- All outputs are 0: `rd_en`, `rd_addr`, `out_valid`, `out_data`, `out_last`, `busy`, `done`, `div_zero`.
- State = IDLE, element counter = 0, sum register = 0.
- Reset mid-operation aborts the vector immediately. No partial output is produced.

FSM states and transitions:
- IDLE → LOAD on `sum_valid`. `sum_in` is latched; `div_zero` is set if `sum_in` == 0, else cleared; `busy` goes to 1.
- LOAD → FETCH after 1 cycle; the element counter is cleared.
- FETCH: `rd_en` = 1 and `rd_addr` = counter for one cycle. → WAIT_RD.
- WAIT_RD: `rd_data` is captured as the dividend. → DIVIDE. If `div_zero` is set, go directly to OUTPUT with quotient 0.
- DIVIDE: restoring division, one quotient bit per cycle.
  - Dividend = exp << FRAC_BITS, width DATA_WIDTH+FRAC_BITS.
  - Takes exactly DATA_WIDTH+FRAC_BITS cycles (31 with defaults). → OUTPUT.
- OUTPUT: `out_valid` = 1.
  - `out_data` = quotient, saturated to 2^DATA_WIDTH-1 if it overflows.
  - `out_last` = (counter == IFM_SIZE-1).
  - `out_data` and `out_last` stay stable while `out_ready` = 0.
  - On the handshake: if last → DONE; else counter+1 → FETCH.
- DONE: `done` = 1 and `busy` = 0 for one cycle. → IDLE.

Latency and ordering:
- Element latency from FETCH to first `out_valid` = 2 + DATA_WIDTH+FRAC_BITS cycles, i.e. 33 with defaults.
- Elements are emitted strictly in address order 0..IFM_SIZE-1. No reordering, no overlap between elements.

Arithmetic:
- All arithmetic is unsigned.
- The remainder register is SUM_WIDTH+1 bits wide.
- When exp ≤ sum, the quotient is ≤ 2^FRAC_BITS and always fits in 16 bits.

Boundary conditions:
- `sum_valid` while `busy`: ignored, and `div_zero` is unchanged.
- `sum_valid` in the same cycle as `done`: ignored. A new sum is accepted only in IDLE.
- IFM_SIZE = 1: the first element carries `out_last`.
- Counter wrap-around: none; the counter never exceeds IFM_SIZE-1.

Optional Feature:

SOFTMAX_NORM_ROUND_EN
- Defined: round-to-nearest, half rounds up. After the division, the quotient is incremented if 2·remainder ≥ sum, then saturated as above. Adds one cycle to DIVIDE.
- Undefined: truncating quotient; DIVIDE is exactly DATA_WIDTH+FRAC_BITS cycles.

Decomposition:
- Shared package softmax_pkg holds:
  - the FSM state encoding (IDLE, LOAD, FETCH, WAIT_RD, DIVIDE, OUTPUT, DONE) as a 3-bit enum;
  - default width constants DATA_WIDTH, SUM_WIDTH, FRAC_BITS;
  - the Q-format constant ONE_Q = 2^FRAC_BITS.
- One sub-module: serial_divider, a parameterized restoring divider.
  - Ports: start, dividend, divisor, busy, done, quotient, remainder.
  - The normalizer instantiates it once; rounding stays in the parent.

Test Plan:
- sum_in = 32768 with buffer [16384, 32768, 0] and IFM_SIZE = 3, `out_ready` held 1 → `out_data` = 0x4000, 0x8000, 0x0000; `out_last` on the 3rd element; `done` 1 cycle after the 3rd handshake; first `out_valid` exactly 33 cycles after FETCH.
- sum_in = 3, exp = 1 → `out_data` = 10922 without the macro, 10923 with SOFTMAX_NORM_ROUND_EN.
- sum_in = 0 → `div_zero` = 1; all IFM_SIZE outputs = 0 with no DIVIDE cycles; `done` still pulses; the next nonzero `sum_valid` clears `div_zero`.
- `out_ready` = 0 for 5 cycles while `out_valid` = 1 → `out_data`, `out_last` and `rd_addr` stable; no new `rd_en`; the next FETCH occurs the cycle after the handshake.
- Second `sum_valid` (sum_in = 7) mid-vector → ignored; all outputs still computed with the original sum.
- `rst` asserted during DIVIDE of element 5 → all outputs 0 in the same cycle; after deassertion the block is in IDLE and a new `sum_valid` restarts from address 0.
